// File: rtl/fifo_chk_pkg.sv
// Shared types for the test FIFO read-side checker.
// Also holds the data pattern the write-side source emits.
package fifo_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    PAUSE = 2'd3
  } state_t;

  localparam logic [127:0] EXP_DEFAULT =
    128'h0000_0000_1234_5678_0000_0000_1234_5678;

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter used for checker statistics.
// Holds at all-ones instead of wrapping.
module sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // count up on inc, stick at the maximum value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (inc && (cnt != '1))
      cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/fifo_rd_checker.sv
// Read-side burst consumer for the width-converting test FIFO.
// Compares every returned word against a fixed pattern.
module fifo_rd_checker
  import fifo_chk_pkg::*;
#(
  parameter int              DW        = 128,
  parameter logic [DW-1:0]   EXP_DATA  = DW'(EXP_DEFAULT),
  parameter int              RD_LAT    = 1,
  parameter int              BURST_LEN = 16,
  parameter int              GAP_LEN   = 8,
  parameter int              CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             empty,
  input  logic             full,
  input  logic [DW-1:0]    rdata,
  output logic             ren,
  output logic             busy,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_flag,
  output logic             full_seen,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [DW-1:0]    first_err_data
);

  localparam int BW = $clog2(BURST_LEN + 1);
  localparam int GW = (GAP_LEN > 0) ? $clog2(GAP_LEN + 1) : 1;

  logic [1:0]        rst_sync;
  logic              rst_n;
  state_t            state;
  state_t            state_nx;
  logic [BW-1:0]     burst_cnt;
  logic [GW-1:0]     gap_cnt;
  logic [RD_LAT-1:0] pipe;
  logic              ren_i;
  logic              vld;
  logic              mism;
  logic              burst_last;
  logic              gap_done;

  // async assert, release synchronised to clk
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      rst_sync <= '0;
    else
      rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  assign ren_i = (state == READ) && !empty &&
                 (burst_cnt < BW'(BURST_LEN));
  assign vld   = pipe[RD_LAT-1];
  assign mism  = vld && (rdata != EXP_DATA);

  assign burst_last = ren_i &&
                      (burst_cnt == BW'(BURST_LEN - 1));
  assign gap_done   = (gap_cnt == GW'(GAP_LEN - 1));

  assign ren  = ren_i;
  assign busy = (state != IDLE);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // next-state: bursts, drain of in-flight reads, gap
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (en)
          state_nx = READ;
      end
      READ: begin
        if (!en || burst_last)
          state_nx = DRAIN;
      end
      DRAIN: begin
        if (pipe == '0) begin
          if (GAP_LEN > 0)
            state_nx = PAUSE;
          else
            state_nx = en ? READ : IDLE;
        end
      end
      PAUSE: begin
        if (gap_done)
          state_nx = en ? READ : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // reads issued in the current burst, zero outside READ
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      burst_cnt <= '0;
    else if (state != READ)
      burst_cnt <= '0;
    else if (ren_i)
      burst_cnt <= burst_cnt + BW'(1);
  end

  // idle cycles spent in PAUSE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      gap_cnt <= '0;
    else if (state != PAUSE)
      gap_cnt <= '0;
    else
      gap_cnt <= gap_cnt + GW'(1);
  end

  // read-latency shift register; tail marks rdata valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pipe <= '0;
    else
      pipe <= RD_LAT'({pipe, ren_i});
  end

  sat_cnt #(.W(CNT_W)) u_rd_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (vld),
    .cnt   (rd_cnt)
  );

  sat_cnt #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (mism),
    .cnt   (err_cnt)
  );

  // sticky flag and first-failure capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_flag       <= 1'b0;
      first_err_idx  <= '0;
      first_err_data <= '0;
    end else if (mism && !err_flag) begin
      err_flag       <= 1'b1;
      first_err_idx  <= rd_cnt;
      first_err_data <= rdata;
    end
  end

  // sticky record of FIFO full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      full_seen <= 1'b0;
    else if (full)
      full_seen <= 1'b1;
  end

endmodule

// File: tb/tb_fifo_rd_checker.sv
// Bench for fifo_rd_checker: two channels, each with a
// queue-based FIFO model and a pop-order scoreboard.
module tb_fifo_rd_checker;

  localparam logic [127:0] EXP =
    128'h0000_0000_1234_5678_0000_0000_1234_5678;
  localparam logic [127:0] JUNK = ~EXP;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic longint sat(input int n, input int w);
    longint m;
    m = (longint'(1) << w) - 1;
    return (n > m) ? m : longint'(n);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : ch
    localparam int LAT = (g == 0) ? 1 : 3;
    localparam int CW  = (g == 0) ? 32 : 4;
    localparam int GL  = (g == 0) ? 8 : 2;

    logic          en = 1'b0;
    logic          full = 1'b0;
    logic          empty;
    logic [127:0]  rdata;
    logic          ren, busy, err_flag, full_seen;
    logic [CW-1:0] rd_cnt, err_cnt, fidx;
    logic [127:0]  fdata;

    bit            force_empty = 1'b0;
    logic [127:0]  q[$];
    logic [128:0]  dl[$];
    int            m_pop = 0;
    int            m_err = 0;
    int            m_fidx = -1;
    logic [127:0]  m_fdata = '0;
    int            cyc = 0;
    int            pop_cyc[$];
    logic          en_hist = 1'b0;

    fifo_rd_checker #(
      .DW(128), .EXP_DATA(EXP), .RD_LAT(LAT),
      .BURST_LEN(16), .GAP_LEN(GL), .CNT_W(CW)
    ) u_dut (
      .clk            (clk),
      .rstn           (rstn),
      .en             (en),
      .empty          (empty),
      .full           (full),
      .rdata          (rdata),
      .ren            (ren),
      .busy           (busy),
      .rd_cnt         (rd_cnt),
      .err_cnt        (err_cnt),
      .err_flag       (err_flag),
      .full_seen      (full_seen),
      .first_err_idx  (fidx),
      .first_err_data (fdata)
    );

    always @(posedge clk) en_hist <= en;

    initial begin : fifo_model
      logic [128:0] e;
      logic [127:0] w;
      empty = 1'b1;
      rdata = JUNK;
      forever begin
        @(negedge clk);
        cyc++;
        if (!rstn) begin
          m_pop = 0;
          m_err = 0;
          m_fidx = -1;
          m_fdata = '0;
          pop_cyc.delete();
        end
        if (dl.size() >= LAT) begin
          e = dl.pop_front();
          rdata = e[128] ? e[127:0] : JUNK;
        end
        empty = force_empty || (q.size() == 0);
        #1;
        if (ren) begin
          chk("ren_while_empty", empty, 0);
          chk("ren_without_en", en_hist, 1);
          w = (q.size() > 0) ? q.pop_front() : JUNK;
          if (w != EXP) begin
            if (m_fidx < 0) begin
              m_fidx = m_pop;
              m_fdata = w;
            end
            m_err++;
          end
          m_pop++;
          pop_cyc.push_back(cyc);
          dl.push_back({1'b1, w});
        end else begin
          dl.push_back({1'b0, JUNK});
        end
      end
    end
  end

  task automatic preload(input int c, input int n,
                         input int ia, input int ib,
                         input bit all_bad);
    logic [127:0] w;
    for (int i = 0; i < n; i++) begin
      w = EXP;
      if (all_bad || i == ib)
        w = {$urandom, $urandom, $urandom, $urandom} | 128'h1;
      if (i == ia)
        w = 128'hDEAD_BEEF;
      if (c == 0) ch[0].q.push_back(w);
      else        ch[1].q.push_back(w);
    end
  endtask

  task automatic wait_pops(input int c, input int n,
                           input int budget);
    int k = 0;
    int p;
    p = (c == 0) ? ch[0].m_pop : ch[1].m_pop;
    while (p < n && k < budget) begin
      @(negedge clk);
      #2;
      k++;
      p = (c == 0) ? ch[0].m_pop : ch[1].m_pop;
    end
    chk("pops_reached", p >= n, 1);
  endtask

  task automatic wait_idle(input int c, input int budget);
    int   k = 0;
    logic b;
    b = (c == 0) ? ch[0].busy : ch[1].busy;
    while (b && k < budget) begin
      @(negedge clk);
      #2;
      k++;
      b = (c == 0) ? ch[0].busy : ch[1].busy;
    end
    chk("idle_reached", b, 0);
  endtask

  task automatic chk_stats(input int c);
    int           pop, err, fi, w;
    logic [127:0] fd;
    logic [31:0]  rc, ec, fx;
    logic         fl;
    if (c == 0) begin
      w = 32; pop = ch[0].m_pop; err = ch[0].m_err;
      fi = ch[0].m_fidx; fd = ch[0].m_fdata;
      rc = ch[0].rd_cnt; ec = ch[0].err_cnt;
      fx = ch[0].fidx; fl = ch[0].err_flag;
      chk("fdata", ch[0].fdata, fd);
    end else begin
      w = 4; pop = ch[1].m_pop; err = ch[1].m_err;
      fi = ch[1].m_fidx; fd = ch[1].m_fdata;
      rc = 32'(ch[1].rd_cnt); ec = 32'(ch[1].err_cnt);
      fx = 32'(ch[1].fidx); fl = ch[1].err_flag;
      chk("fdata", ch[1].fdata, fd);
    end
    chk("rd_cnt", rc, sat(pop, w));
    chk("err_cnt", ec, sat(err, w));
    chk("err_flag", fl, fi >= 0);
    chk("first_idx", fx, (fi < 0) ? 0 : sat(fi, w));
  endtask

  task automatic do_reset(input int c0_words,
                          input int ia, input int ib);
    @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    ch[0].q.delete();
    preload(0, c0_words, ia, ib, 1'b0);
    rstn = 1'b1;
  endtask

  initial begin
    int snap;
    int k;

    repeat (3) @(negedge clk);
    chk("rst_rd_cnt", ch[0].rd_cnt, 0);
    chk("rst_err_cnt", ch[0].err_cnt, 0);
    chk("rst_err_flag", ch[0].err_flag, 0);
    chk("rst_busy", ch[0].busy, 0);
    chk("rst_ren", ch[0].ren, 0);
    chk("rst_full_seen", ch[0].full_seen, 0);
    chk("rst_fidx", ch[0].fidx, 0);
    chk("rst_fdata", ch[0].fdata, 0);
    chk("rst_busy1", ch[1].busy, 0);
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    // 16 good words, one burst
    preload(0, 16, -1, -1, 1'b0);
    ch[0].en = 1'b1;
    wait_pops(0, 16, 200);
    repeat (20) @(negedge clk);
    chk("t1_pops", ch[0].m_pop, 16);
    chk("t1_rd_cnt", ch[0].rd_cnt, 16);
    chk("t1_run", ch[0].pop_cyc[15] - ch[0].pop_cyc[0], 15);
    chk("t1_busy", ch[0].busy, 1);
    chk_stats(0);

    // errors at index 5 and 9, burst boundary
    do_reset(24, 5, 9);
    wait_pops(0, 24, 300);
    repeat (20) @(negedge clk);
    chk("t2_err_cnt", ch[0].err_cnt, 2);
    chk("t2_fidx", ch[0].fidx, 5);
    chk("t2_fdata", ch[0].fdata, 128'hDEAD_BEEF);
    chk("t2_run", ch[0].pop_cyc[15] - ch[0].pop_cyc[0], 15);
    chk("t2_gap", (ch[0].pop_cyc[16] - ch[0].pop_cyc[15]) > 8, 1);
    chk_stats(0);

    // empty stall mid-burst
    preload(0, 16, -1, -1, 1'b0);
    wait_pops(0, 28, 200);
    ch[0].force_empty = 1'b1;
    @(negedge clk);
    snap = ch[0].m_pop;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #2;
      chk("t3_ren_low", ch[0].ren, 0);
    end
    chk("t3_stall", ch[0].m_pop, snap);
    ch[0].force_empty = 1'b0;
    wait_pops(0, 40, 300);
    repeat (20) @(negedge clk);
    chk("t3_rd_cnt", ch[0].rd_cnt, 40);
    chk_stats(0);

    // channel 1: en dropped with the 3rd read, RD_LAT=3
    preload(1, 16, -1, -1, 1'b0);
    ch[1].en = 1'b1;
    k = 0;
    while (ch[1].m_pop < 3 && k < 100) begin
      @(negedge clk);
      #2;
      k++;
    end
    ch[1].en = 1'b0;
    chk("t4_three", ch[1].m_pop, 3);
    wait_idle(1, 100);
    chk("t4_rd_cnt", ch[1].rd_cnt, 3);
    repeat (10) @(negedge clk);
    chk("t4_no_more", ch[1].m_pop, 3);
    chk_stats(1);

    // reset with two bad words in flight
    ch[1].q.delete();
    preload(1, 16, -1, -1, 1'b1);
    ch[1].en = 1'b1;
    wait_pops(1, 5, 100);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    chk("t5_rd_cnt", ch[1].rd_cnt, 0);
    chk("t5_busy", ch[1].busy, 0);
    chk("t5_ren", ch[1].ren, 0);
    chk("t5_rd_cnt0", ch[0].rd_cnt, 0);
    chk("t5_flag0", ch[0].err_flag, 0);
    ch[1].en = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    chk("t5_after_rd", ch[1].rd_cnt, 0);
    chk("t5_after_err", ch[1].err_cnt, 0);
    chk("t5_after_flag", ch[1].err_flag, 0);

    // saturation at CNT_W=4, full pulse
    ch[1].q.delete();
    preload(1, 20, -1, -1, 1'b1);
    ch[1].en = 1'b1;
    wait_pops(1, 20, 300);
    ch[1].en = 1'b0;
    wait_idle(1, 100);
    chk("t6_rd_sat", ch[1].rd_cnt, 15);
    chk("t6_err_sat", ch[1].err_cnt, 15);
    chk("t6_fidx", ch[1].fidx, 0);
    chk_stats(1);
    @(negedge clk);
    ch[1].full = 1'b1;
    @(negedge clk);
    ch[1].full = 1'b0;
    repeat (5) @(negedge clk);
    chk("t6_full_seen", ch[1].full_seen, 1);
    chk("t6_full_seen0", ch[0].full_seen, 0);

    // randomized traffic on channel 0
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 2) == 0)
        preload(0, 1, -1, -1, $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0)
        ch[0].force_empty = ~ch[0].force_empty;
      if ($urandom_range(0, 31) == 0)
        ch[0].en = ~ch[0].en;
    end
    ch[0].force_empty = 1'b0;
    ch[0].en = 1'b0;
    wait_idle(0, 200);
    repeat (5) @(negedge clk);
    chk_stats(0);

    // final reset clears sticky state
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("fin_full_seen", ch[1].full_seen, 0);
    chk("fin_flag1", ch[1].err_flag, 0);
    chk("fin_rd_cnt0", ch[0].rd_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_rd_checker.md
Name: fifo_rd_checker

Overview:
- Read-side consumer for the width-converting test FIFO (64-bit write, 128-bit read).
- Runs in the memory clock domain and drains the FIFO in bursts.
- Accounts for the FIFO's registered read latency and compares every word against a fixed expected pattern.
- Keeps word/error statistics, a sticky error flag and first-failure capture for debug probes (GAO) or LEDs.

Parameters:
- DW, 128, read data width.
- EXP_DATA, 128'h0000_0000_1234_5678_0000_0000_1234_5678, expected value of every read word.
- RD_LAT, 1, cycles from ren sampled high to rdata valid (1..4).
- BURST_LEN, 16, maximum reads issued per burst (>=1).
- GAP_LEN, 8, idle cycles between bursts (>=0).
- CNT_W, 32, width of statistics counters.

Ports:
- clk  in  1  memory-side clock (FIFO RdClk).
- rstn  in  1  asynchronous active-low reset.
- en  in  1  level enable; 0 stops new bursts.
- empty  in  1  FIFO Empty.
- full  in  1  FIFO Full (monitored only).
- rdata  in  DW  FIFO Q.
- ren  out  1  FIFO RdEn.
- busy  out  1  state != IDLE.
- rd_cnt  out  CNT_W  words checked.
- err_cnt  out  CNT_W  mismatching words.
- err_flag  out  1  sticky, set on first mismatch.
- full_seen  out  1  sticky, set when full sampled high.
- first_err_idx  out  CNT_W  rd_cnt value of first mismatching word.
- first_err_data  out  DW  rdata of first mismatching word.

Behaviour:
- Reset (async assert, sync release by clk): state=IDLE, all outputs and counters 0, latency pipe cleared. Reset mid-burst discards any outstanding words.
- ren = (state==READ) & ~empty & (burst_cnt < BURST_LEN). It is combinational from registered state, so ren never asserts while empty is high.
- Latency pipe: RD_LAT-deep shift register of ren. Its tail is vld, which marks rdata valid in that cycle.
- On vld:
  - rd_cnt increments.
  - If rdata != EXP_DATA, err_cnt increments.
  - If err_flag==0 at that mismatch: set err_flag, capture first_err_idx = pre-increment rd_cnt and first_err_data = rdata.
- rd_cnt and err_cnt saturate at all-ones and never wrap.
- full_seen is set on any cycle with full=1 and clears only on reset.
- State machine:
  - IDLE: burst_cnt=0. If en, go to READ next cycle.
  - READ: burst_cnt increments on each ren. Leave for DRAIN when burst_cnt reaches BURST_LEN, or when en=0. If empty persists, stay in READ with ren=0; no timeout.
  - DRAIN: ren=0; wait until the latency pipe is all zero (at most RD_LAT cycles). Then go to PAUSE if GAP_LEN>0, else go straight to the next-burst decision.
  - PAUSE: count GAP_LEN cycles, then go to READ if en, else IDLE. burst_cnt clears on entry to READ.
- Simultaneous cases:
  - en falling in the same cycle as ren: that read completes and is checked.
  - empty rising mid-burst: ren drops that cycle and the burst resumes when empty falls.
  - vld while the state machine is in DRAIN/PAUSE/IDLE: the word is always checked.
- Statistics persist across bursts and across en toggles.

Decomposition:
- Package fifo_chk_pkg: state enum (IDLE, READ, DRAIN, PAUSE) and the default EXP_DATA constant shared with the write-side pattern source.
- No sub-module required. The saturating counter may be a small shared sub-module, sat_cnt, instantiated twice.

Test Plan:
- Reset then en=1, FIFO model preloaded with 16 correct words, RD_LAT=1 -> exactly 16 ren pulses, rd_cnt=16, err_cnt=0, err_flag=0, busy returns high after a GAP_LEN=8 cycle pause.
- Word index 5 corrupted to 128'hDEAD_BEEF -> err_cnt=1, err_flag=1, first_err_idx=5, first_err_data=128'hDEAD_BEEF. A second error at index 9 leaves the capture unchanged and gives err_cnt=2.
- empty held high for 10 cycles mid-burst -> ren=0 throughout those cycles, no spurious vld, burst completes after empty falls with rd_cnt still correct.
- en dropped after the 3rd ren of a burst, RD_LAT=3 -> all 3 words checked during DRAIN, state reaches IDLE, busy=0, no further ren.
- rstn asserted mid-burst with 2 words outstanding -> all outputs 0 immediately (async), no check of outstanding words after release.
- CNT_W=4 with 20 mismatching words -> rd_cnt and err_cnt stick at 15; full pulsed once -> full_seen=1 until reset.
